// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared types and widths for the hazard unit and its slot pipe
package hazard_unit_pkg;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwr;
    logic             load;
  } slot_t;
endpackage

// File: rtl/hazard_slot_pipe.sv
// hazard_slot_pipe: EX/MEM/WB shadow slots that shift on advance and hold on freeze
module hazard_slot_pipe
  import hazard_unit_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  advance,
  input  slot_t id_slot,
  output slot_t ex,
  output slot_t mem,
  output slot_t wb
);
  always_ff @(posedge CLK)
    if (RST) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (advance) begin
      wb  <= mem;
      mem <= ex;
      ex  <= id_slot;
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, memory-wait freeze and branch flush control with stall counter
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwr,
  input  logic             id_load,
  input  logic             dmem_wait,
  input  logic             branch_taken,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             freeze_all,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic             mem_regwr,
  output logic             wb_regwr,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t state, state_nx;
  slot_t  ex, mem, wb, id_slot;
  logic   hazard, hz_cycle, unused_load;
  hazard_slot_pipe u_pipe (
    .CLK     (CLK),
    .RST     (RST),
    .advance (!freeze_all),
    .id_slot (id_slot),
    .ex      (ex),
    .mem     (mem),
    .wb      (wb)
  );
  assign unused_load = mem.load ^ wb.load;
  // A hazard pending when MEM_WAIT releases is acted on in that same unfrozen cycle,
  // so the dependent instruction can never slip into EX alongside its load.
  always_comb begin
    hazard      = ex.valid && ex.load && ex.regwr && ex.rd != '0 &&
                  (ex.rd == id_rs || (id_uses_rt && ex.rd == id_rt));
    freeze_all  = dmem_wait;
    flush_ifid  = branch_taken && !freeze_all;
    bubble_idex = hazard && !freeze_all;
    hz_cycle    = bubble_idex && !branch_taken;
    stall_pc    = freeze_all || hz_cycle;
    stall_ifid  = stall_pc;
    id_slot     = (id_valid && !bubble_idex && !flush_ifid) ?
                  slot_t'{1'b1, id_rd, id_regwr, id_load} : slot_t'('0);
    state_nx    = dmem_wait ? MEM_WAIT : (state == RUN && hz_cycle) ? LU_STALL : RUN;
    mem_rd      = mem.rd;
    wb_rd       = wb.rd;
    mem_regwr   = mem.valid && mem.regwr && mem.rd != '0;
    wb_regwr    = wb.valid && wb.regwr && wb.rd != '0;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (hz_cycle && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench comparing hazard_unit against a cycle model
module tb_hazard_unit;
  logic CLK = 0, RST = 0, id_valid = 0, id_uses_rt = 0, id_regwr = 0, id_load = 0;
  logic dmem_wait = 0, branch_taken = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all, mem_regwr, wb_regwr;
  logic [4:0] mem_rd, wb_rd;
  logic [15:0] stall_cnt;
  int errors = 0, checks = 0;
  always #5 CLK = ~CLK;
  hazard_unit dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwr(id_regwr), .id_load(id_load),
    .dmem_wait(dmem_wait), .branch_taken(branch_taken), .stall_pc(stall_pc),
    .stall_ifid(stall_ifid), .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
    .freeze_all(freeze_all), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwr(mem_regwr),
    .wb_regwr(wb_regwr), .stall_cnt(stall_cnt)
  );
  typedef struct { logic v; logic [4:0] rd; logic wr; logic ld; } mslot_t;
  typedef struct {
    logic spc, sif, bub, fl, frz, mwr, wwr;
    logic [4:0] mrd, wrd;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];
  mslot_t m_ex, m_mem, m_wb;
  int m_cnt = 0;
  bit m_known = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit rst, input bit v, input logic [4:0] rs, input logic [4:0] rt,
                      input bit urt, input logic [4:0] rd, input bit wr, input bit ld,
                      input bit dw, input bit bt);
    exp_t e;
    logic hz;
    @(negedge CLK);
    RST = rst; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_rd = rd; id_regwr = wr; id_load = ld; dmem_wait = dw; branch_taken = bt;
    hz = m_ex.v && m_ex.ld && m_ex.wr && m_ex.rd != 0 && (m_ex.rd == rs || (urt && m_ex.rd == rt));
    if (m_known) begin
      e.frz = dw;
      e.fl  = bt && !dw;
      e.bub = hz && !dw;
      e.spc = dw || (hz && !bt);
      e.sif = e.spc;
      e.mrd = m_mem.rd;
      e.wrd = m_wb.rd;
      e.mwr = m_mem.v && m_mem.wr && m_mem.rd != 0;
      e.wwr = m_wb.v && m_wb.wr && m_wb.rd != 0;
      e.cnt = 16'(m_cnt);
      sb.push_back(e);
    end
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("stall_pc", 32'(stall_pc), 32'(e.spc));
      check("stall_ifid", 32'(stall_ifid), 32'(e.sif));
      check("bubble_idex", 32'(bubble_idex), 32'(e.bub));
      check("flush_ifid", 32'(flush_ifid), 32'(e.fl));
      check("freeze_all", 32'(freeze_all), 32'(e.frz));
      check("mem_rd", 32'(mem_rd), 32'(e.mrd));
      check("wb_rd", 32'(wb_rd), 32'(e.wrd));
      check("mem_regwr", 32'(mem_regwr), 32'(e.mwr));
      check("wb_regwr", 32'(wb_regwr), 32'(e.wwr));
      check("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    end
    if (rst) begin
      m_ex = '{0, 0, 0, 0}; m_mem = m_ex; m_wb = m_ex; m_cnt = 0; m_known = 1;
    end else if (m_known) begin
      if (hz && !dw && !bt && m_cnt < 65535) m_cnt++;
      if (!dw) begin
        m_wb = m_mem;
        m_mem = m_ex;
        m_ex = (v && !hz && !bt) ? '{1'b1, rd, wr, ld} : '{1'b0, 5'd0, 1'b0, 1'b0};
      end
    end
  endtask
  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic lw(input logic [4:0] rd);
    step(0, 1, 0, 0, 0, rd, 1, 1, 0, 0);
  endtask
  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input bit urt, input logic [4:0] rd);
    step(0, 1, rs, rt, urt, rd, 1, 0, 0, 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(1);
    check("rst_stall_pc", 32'(stall_pc), 0);
    check("rst_freeze", 32'(freeze_all), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    lw(0);
    alu(0, 0, 1, 3);
    check("r0_no_stall", 32'(stall_pc), 0);
    nop(1);
    check("r0_cnt", 32'(stall_cnt), 0);
    lw(5);
    alu(5, 6, 1, 7);
    check("lu_rs_stall_pc", 32'(stall_pc), 1);
    check("lu_rs_stall_ifid", 32'(stall_ifid), 1);
    check("lu_rs_bubble", 32'(bubble_idex), 1);
    alu(5, 6, 1, 7);
    check("lu_rs_after", 32'(stall_pc), 0);
    check("lu_rs_cnt", 32'(stall_cnt), 1);
    alu(8, 9, 1, 10);
    check("lu_rs_run", 32'(stall_pc), 0);
    lw(6);
    alu(1, 6, 1, 2);
    check("lu_rt_stall", 32'(stall_pc), 1);
    lw(6);
    alu(1, 6, 0, 2);
    check("rt_unused_no_stall", 32'(stall_pc), 0);
    step(0, 1, 0, 0, 0, 11, 1, 0, 0, 0);
    alu(11, 0, 0, 12);
    check("nonload_no_stall", 32'(stall_pc), 0);
    lw(9);
    step(0, 1, 9, 0, 0, 12, 1, 0, 0, 1);
    check("flush_fl", 32'(flush_ifid), 1);
    check("flush_bubble", 32'(bubble_idex), 1);
    check("flush_stall_pc", 32'(stall_pc), 0);
    nop(1);
    check("flush_cnt", 32'(stall_cnt), 2);
    alu(1, 2, 0, 12);
    alu(1, 2, 0, 13);
    alu(1, 2, 0, 14);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 20, 21, 1, 22, 1, 0, 1, 1);
      check("wait_freeze", 32'(freeze_all), 1);
      check("wait_mem_rd", 32'(mem_rd), 13);
      check("wait_wb_rd", 32'(wb_rd), 12);
      check("wait_bubble", 32'(bubble_idex), 0);
    end
    nop(1);
    check("wait_done_freeze", 32'(freeze_all), 0);
    check("wait_done_mem_rd", 32'(mem_rd), 13);
    nop(1);
    check("wait_shift_mem_rd", 32'(mem_rd), 14);
    lw(3);
    step(0, 1, 3, 0, 0, 4, 1, 0, 1, 0);
    step(0, 1, 3, 0, 0, 4, 1, 0, 1, 0);
    alu(3, 0, 0, 4);
    check("wait_exit_bubble", 32'(bubble_idex), 1);
    nop(1);
    check("wait_exit_cnt", 32'(stall_cnt), 3);
    lw(4);
    alu(1, 2, 0, 15);
    step(0, 1, 4, 0, 0, 5, 1, 0, 1, 0);
    step(0, 1, 4, 0, 0, 5, 1, 0, 1, 0);
    step(1, 1, 4, 0, 0, 5, 1, 0, 1, 1);
    nop(1);
    check("rst_wait_freeze", 32'(freeze_all), 0);
    check("rst_wait_stall", 32'(stall_pc), 0);
    check("rst_wait_mem_regwr", 32'(mem_regwr), 0);
    check("rst_wait_wb_regwr", 32'(wb_regwr), 0);
    check("rst_wait_cnt", 32'(stall_cnt), 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) begin
      lw(5);
      alu(5, 0, 0, 1);
    end
    nop(1);
    check("sat_preload", 32'(stall_cnt), 32'hFFFF);
    lw(5);
    alu(5, 0, 0, 1);
    check("sat_stall", 32'(stall_pc), 1);
    nop(1);
    check("sat_hold", 32'(stall_cnt), 32'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
